coherence_bus_arbiter: RTL and testbench
========================================

// Module: coherence_bus_arbiter
// PURPOSE
//  Owns the single shared snooping bus of the MSI multicore cache model.
//  Grants one cache controller (sm_cpu side) at a time, round-robin, and broadcasts its
//  transaction (read miss / write miss / invalidate) to all snoopers (sm_bus side).
//  Collects snoop write-back responses, then sequences the write-back and the memory access.
//  Signals completion to the requester.
// PARAMETERS
//  NUM_CACHES   4   number of requesting cache controllers (>=2)
//  SRC_W        2   width of requester index, = clog2(NUM_CACHES)
//  MEM_LATENCY  3   cycles a memory read occupies the bus (>=1)
//  WB_LATENCY   2   cycles a snooper write-back occupies the bus (>=1)
// PORTS
//  clock      in   1             rising-edge clock
//  reset_n    in   1             asynchronous, active-low reset
//  req        in   NUM_CACHES    per-cache request, held until done
//  req_op     in   2*NUM_CACHES  per-cache op [2i+1:2i]: 01 readMiss, 10 writeMiss, 11 invalidate, 00 none
//  snoop_wb   in   NUM_CACHES    snooper i holds block Modified and must write back; valid in SNOOP only
//  grant      out  NUM_CACHES    one-hot owner of bus, BCAST..DONE inclusive
//  bus_valid  out  1             broadcast strobe, exactly one cycle per transaction (BCAST)
//  bus_op     out  2             op of current owner; held BCAST..DONE, 00 otherwise
//  bus_src    out  SRC_W         index of current owner
//  write_back out  1             high during WRITEBACK state
//  abort_mem  out  1             high WRITEBACK..DONE when a snooper supplied data
//  done       out  NUM_CACHES    one-cycle pulse to owner in DONE
//  state      out  3             FSM state for display/debug
// BEHAVIOUR
//  Reset: state=IDLE(000), rr pointer=0; grant, bus_valid, bus_op, bus_src, write_back,
//   abort_mem, done all 0. Async assert mid-transaction aborts it; no done pulse is issued.
//  Valid request i: req[i]=1 and req_op[i]!=00; req with op 00 is ignored.
//  States: IDLE 000, BCAST 001, SNOOP 010, WRITEBACK 011, MEM 100, DONE 101.
//  IDLE: if any valid request, register winner/op, go BCAST; else stay.
//  Round-robin: search starts at rr pointer, wraps NUM_CACHES-1 -> 0;
//   after grant to i, pointer = i+1 mod NUM_CACHES.
//  BCAST: bus_valid=1 for 1 cycle -> SNOOP.
//  SNOOP: sample snoop_wb, masked by ~grant (owner's own bit ignored).
//   Any masked bit set and op!=invalidate -> WRITEBACK; otherwise op=invalidate -> DONE;
//   otherwise -> MEM.
//  WRITEBACK: WB_LATENCY cycles, write_back=1, abort_mem set; then DONE (memory read skipped).
//  MEM: MEM_LATENCY cycles -> DONE.
//  DONE: done[owner]=1 for 1 cycle; grant/bus_op/abort_mem cleared on exit -> IDLE.
//  Requester must drop req the cycle after done; req still high in the following IDLE cycle
//   is treated as a new request.
//  req/req_op changes by the owner after IDLE are ignored; op is latched.
//  Requests from non-owners wait; none are lost while held.
//  Multiple snoop_wb bits: single WRITEBACK phase (MSI guarantees at most one in practice).
//  Latency, request seen in IDLE at cycle 0:
//   invalidate                  -> done at cycle 3
//   miss, no write-back         -> done at cycle 3+MEM_LATENCY
//   miss with write-back        -> done at cycle 3+WB_LATENCY
//  Latency counter is width-safe for max(MEM_LATENCY, WB_LATENCY); it resets on each state entry.
// TESTING
//  1. Reset: reset_n=0 with req=1111 -> all outputs 0, state=000; release -> BCAST next cycle.
//  2. req[1]=1, op=01, snoop_wb=0 (defaults) -> bus_valid cycle 1, bus_src=1,
//     done[1] at cycle 6, abort_mem=0.
//  3. req[0] op=10, snoop_wb[2]=1 in SNOOP -> write_back 2 cycles, abort_mem=1,
//     done[0] at cycle 5, no MEM state.
//  4. req=1111 held, ops all 11 -> grants in order 0,1,2,3,0; each done 3 cycles after its IDLE.
//  5. Owner's own snoop_wb bit=1, op=01 -> ignored, MEM path taken, done at cycle 6.
//  6. reset_n pulsed low during MEM -> immediate IDLE, no done pulse; rr pointer back to 0.

Source files
------------

// File: rtl/coherence_bus_arbiter_if.sv
// Shared snooping bus between the bus arbiter (master) and the cache controllers (slave).
// Request, op and snoop lines come from the caches; grant, broadcast and completion lines come from the arbiter.
interface coherence_bus_arbiter_if #(
    parameter int unsigned NUM_CACHES = 4,
    parameter int unsigned SRC_W      = 2
);
    logic [NUM_CACHES-1:0]   req;
    logic [2*NUM_CACHES-1:0] req_op;
    logic [NUM_CACHES-1:0]   snoop_wb;
    logic [NUM_CACHES-1:0]   grant;
    logic                    bus_valid;
    logic [1:0]              bus_op;
    logic [SRC_W-1:0]        bus_src;
    logic                    write_back;
    logic                    abort_mem;
    logic [NUM_CACHES-1:0]   done;
    logic [2:0]              state;

    modport master (
        input  req, req_op, snoop_wb,
        output grant, bus_valid, bus_op, bus_src, write_back, abort_mem, done, state
    );

    modport slave (
        output req, req_op, snoop_wb,
        input  grant, bus_valid, bus_op, bus_src, write_back, abort_mem, done, state
    );
endinterface

// File: rtl/coherence_bus_arbiter.sv
// Round-robin owner of the MSI snooping bus: grants one cache, broadcasts its op,
// then sequences either a snooper write-back or a memory access before signalling done.
module coherence_bus_arbiter #(
    parameter int unsigned NUM_CACHES  = 4,
    parameter int unsigned SRC_W       = 2,
    parameter int unsigned MEM_LATENCY = 3,
    parameter int unsigned WB_LATENCY  = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    coherence_bus_arbiter_if.master bus
);
    localparam int unsigned MAX_LAT = (MEM_LATENCY > WB_LATENCY) ? MEM_LATENCY : WB_LATENCY;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [1:0]  OP_NONE = 2'b00;
    localparam logic [1:0]  OP_INV  = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        BCAST     = 3'b001,
        SNOOP     = 3'b010,
        WRITEBACK = 3'b011,
        MEM       = 3'b100,
        DONE      = 3'b101
    } stateT;

    stateT                 stateQ, stateNext;
    logic [SRC_W-1:0]      ownerQ, ownerNext;
    logic [SRC_W-1:0]      rrPtrQ, rrPtrNext;
    logic [1:0]            opQ, opNext;
    logic [CNT_W-1:0]      latCntQ, latCntNext;
    logic                  abortQ, abortNext;
    logic [NUM_CACHES-1:0] grantQ, grantNext;
    logic [NUM_CACHES-1:0] doneQ, doneNext;
    logic                  busValidQ, busValidNext;
    logic                  writeBackQ, writeBackNext;
    logic [1:0]            busOpQ, busOpNext;
    logic [SRC_W-1:0]      busSrcQ, busSrcNext;

    logic [NUM_CACHES-1:0] validReq;
    logic                  winFound;
    logic [SRC_W-1:0]      winIdx;
    logic [SRC_W-1:0]      winNextPtr;
    logic [SRC_W-1:0]      cand;
    logic [1:0]            winOp;

    // Round-robin pick: first valid requester at or after the pointer, wrapping.
    always_comb begin
        winFound   = 1'b0;
        winIdx     = '0;
        winNextPtr = '0;
        cand       = '0;
        winOp      = OP_NONE;
        for (int unsigned i = 0; i < NUM_CACHES; i++) begin
            validReq[i] = bus.req[i] && (bus.req_op[2*i +: 2] != OP_NONE);
        end
        for (int unsigned k = 0; k < NUM_CACHES; k++) begin
            cand = SRC_W'((32'(rrPtrQ) + k) % NUM_CACHES);
            if (!winFound && validReq[cand]) begin
                winFound   = 1'b1;
                winIdx     = cand;
                winNextPtr = SRC_W'((32'(rrPtrQ) + k + 1) % NUM_CACHES);
                winOp      = bus.req_op[{cand, 1'b0} +: 2];
            end
        end
    end

    always_comb begin
        stateNext = stateQ;
        ownerNext = ownerQ;
        opNext    = opQ;
        rrPtrNext = rrPtrQ;
        abortNext = abortQ;

        case (stateQ)
            IDLE: begin
                if (winFound) begin
                    stateNext = BCAST;
                    ownerNext = winIdx;
                    opNext    = winOp;
                    rrPtrNext = winNextPtr;
                    abortNext = 1'b0;
                end
            end
            BCAST: stateNext = SNOOP;
            SNOOP: begin
                // The owner's own snoop bit is masked off through the registered grant.
                if ((|(bus.snoop_wb & ~grantQ)) && (opQ != OP_INV)) begin
                    stateNext = WRITEBACK;
                    abortNext = 1'b1;
                end else if (opQ == OP_INV) begin
                    stateNext = DONE;
                end else begin
                    stateNext = MEM;
                end
            end
            WRITEBACK: if (latCntQ == CNT_W'(WB_LATENCY - 1)) stateNext = DONE;
            MEM:       if (latCntQ == CNT_W'(MEM_LATENCY - 1)) stateNext = DONE;
            DONE: begin
                stateNext = IDLE;
                abortNext = 1'b0;
            end
            default: stateNext = IDLE;
        endcase

        latCntNext = (stateNext != stateQ) ? '0 : latCntQ + CNT_W'(1);

        // Registered outputs follow the state being entered, so they line up with it.
        grantNext     = '0;
        doneNext      = '0;
        busOpNext     = OP_NONE;
        busSrcNext    = '0;
        busValidNext  = (stateNext == BCAST);
        writeBackNext = (stateNext == WRITEBACK);
        if (stateNext != IDLE) begin
            grantNext[ownerNext] = 1'b1;
            busOpNext            = opNext;
            busSrcNext           = ownerNext;
        end
        if (stateNext == DONE) begin
            doneNext[ownerNext] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stateQ     <= IDLE;
            ownerQ     <= '0;
            rrPtrQ     <= '0;
            opQ        <= OP_NONE;
            latCntQ    <= '0;
            abortQ     <= 1'b0;
            grantQ     <= '0;
            doneQ      <= '0;
            busValidQ  <= 1'b0;
            writeBackQ <= 1'b0;
            busOpQ     <= OP_NONE;
            busSrcQ    <= '0;
        end else begin
            stateQ     <= stateNext;
            ownerQ     <= ownerNext;
            rrPtrQ     <= rrPtrNext;
            opQ        <= opNext;
            latCntQ    <= latCntNext;
            abortQ     <= abortNext;
            grantQ     <= grantNext;
            doneQ      <= doneNext;
            busValidQ  <= busValidNext;
            writeBackQ <= writeBackNext;
            busOpQ     <= busOpNext;
            busSrcQ    <= busSrcNext;
        end
    end

    assign bus.grant      = grantQ;
    assign bus.done       = doneQ;
    assign bus.bus_valid  = busValidQ;
    assign bus.write_back = writeBackQ;
    assign bus.bus_op     = busOpQ;
    assign bus.bus_src    = busSrcQ;
    assign bus.abort_mem  = abortQ;
    assign bus.state      = stateQ;
endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Bench for coherence_bus_arbiter: directed bring-up steps followed by randomized traffic,
// each transaction checked cycle by cycle against a transaction-level model of the bus.
module tb_coherence_bus_arbiter;
    localparam int unsigned N    = 4;
    localparam int unsigned SW   = 2;
    localparam int unsigned MEML = 3;
    localparam int unsigned WBL  = 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BCAST = 3'd1;
    localparam logic [2:0] S_SNOOP = 3'd2;
    localparam logic [2:0] S_WB    = 3'd3;
    localparam logic [2:0] S_MEM   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    coherence_bus_arbiter_if #(.NUM_CACHES(N), .SRC_W(SW)) bus ();

    coherence_bus_arbiter #(
        .NUM_CACHES (N),
        .SRC_W      (SW),
        .MEM_LATENCY(MEML),
        .WB_LATENCY (WBL)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model state: pending requests as the caches present them, and the round-robin pointer.
    logic [N-1:0] reqM;
    logic [1:0]   opM [N];
    int           rrModel = 0;
    int           order [5] = '{0, 1, 2, 3, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req[i]          = reqM[i];
            bus.req_op[2*i +: 2] = opM[i];
        end
    endtask

    // Winner = valid requester with the smallest forward distance from the pointer.
    function automatic int pickWinner(input int rr);
        int best;
        int bestDist;
        int d;
        best     = -1;
        bestDist = N;
        for (int i = 0; i < N; i++) begin
            if (reqM[i] && opM[i] != 2'b00) begin
                d = (i - rr + N) % N;
                if (d < bestDist) begin
                    bestDist = d;
                    best     = i;
                end
            end
        end
        return best;
    endfunction

    task automatic checkOut(input string tag, input logic [2:0] st, input int owner,
                            input logic [1:0] op, input bit active, input bit bv,
                            input bit wbx, input bit ab, input bit dn);
        logic [N-1:0] oh;
        oh = '0;
        if (active) oh[owner] = 1'b1;
        chk({tag, ".state"},     bus.state, st);
        chk({tag, ".grant"},     bus.grant, oh);
        chk({tag, ".bus_valid"}, bus.bus_valid, bv);
        chk({tag, ".bus_op"},    bus.bus_op, active ? op : 2'b00);
        chk({tag, ".bus_src"},   bus.bus_src, active ? owner : 0);
        chk({tag, ".write_back"}, bus.write_back, wbx);
        chk({tag, ".abort_mem"}, bus.abort_mem, ab);
        chk({tag, ".done"},      bus.done, dn ? oh : '0);
    endtask

    // Called at a negedge with the DUT in IDLE and the requests already driven (cycle 0).
    task automatic runTxn(input logic [N-1:0] snoopPat, input bit mutateOp, input bit holdOwner,
                          input bit junk, output int src);
        int           w;
        logic [1:0]   op;
        logic [N-1:0] masked;
        logic [2:0]   mid;
        int           lat;
        bit           abortExp;
        int           cyc;
        int           doneAt;
        int           expDone;

        chk("txn.start_idle", bus.state, S_IDLE);
        w = pickWinner(rrModel);
        if (w < 0) w = 0;
        op       = opM[w];
        masked   = snoopPat;
        masked[w] = 1'b0;
        abortExp = 1'b0;
        mid      = S_MEM;
        if (op == 2'b11) begin
            lat = 0;
        end else if (masked != '0) begin
            lat      = WBL;
            mid      = S_WB;
            abortExp = 1'b1;
        end else begin
            lat = MEML;
        end
        expDone = (op == 2'b11) ? 3 : ((masked != '0) ? 3 + WBL : 3 + MEML);
        rrModel = (w + 1) % N;
        cyc     = 0;
        doneAt  = -1;

        @(negedge clock); cyc++;
        if (bus.done !== '0 && doneAt < 0) doneAt = cyc;
        src = int'(bus.bus_src);
        checkOut("bcast", S_BCAST, w, op, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        if (mutateOp) begin
            opM[w] = 2'($urandom_range(0, 3));
            drive();
        end
        bus.snoop_wb = junk ? N'($urandom) : '0;

        @(negedge clock); cyc++;
        if (bus.done !== '0 && doneAt < 0) doneAt = cyc;
        checkOut("snoop", S_SNOOP, w, op, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.snoop_wb = snoopPat;

        for (int k = 0; k < lat; k++) begin
            @(negedge clock); cyc++;
            if (bus.done !== '0 && doneAt < 0) doneAt = cyc;
            bus.snoop_wb = junk ? N'($urandom) : '0;
            checkOut((mid == S_WB) ? "wback" : "mem", mid, w, op, 1'b1, 1'b0,
                     (mid == S_WB), abortExp, 1'b0);
        end

        @(negedge clock); cyc++;
        if (bus.done !== '0 && doneAt < 0) doneAt = cyc;
        checkOut("done", S_DONE, w, op, 1'b1, 1'b0, 1'b0, abortExp, 1'b1);
        chk("done_cycle", doneAt, expDone);
        if (!holdOwner) begin
            reqM[w] = 1'b0;
            drive();
        end
        bus.snoop_wb = junk ? N'($urandom) : '0;

        @(negedge clock);
        checkOut("post_idle", S_IDLE, 0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int src;
        int r;
        logic [N-1:0] snp;

        // Reset held with every cache requesting.
        reqM = '1;
        for (int i = 0; i < N; i++) opM[i] = 2'b01;
        bus.snoop_wb = '0;
        drive();
        reset_n = 1'b0;
        @(negedge clock);
        checkOut("reset", S_IDLE, 0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        rrModel = 0;
        runTxn('0, 1'b0, 1'b0, 1'b0, src);
        chk("reset_first_owner", src, 0);
        reqM = '0;
        drive();

        // Read miss, no snoop response: memory path.
        reqM[1] = 1'b1; opM[1] = 2'b01; drive();
        runTxn('0, 1'b0, 1'b0, 1'b0, src);
        chk("rmiss_src", src, 1);

        // Write miss with snooper 2 holding the block Modified.
        reqM[0] = 1'b1; opM[0] = 2'b10; drive();
        runTxn(4'b0100, 1'b0, 1'b0, 1'b0, src);

        // Owner's own snoop bit must be ignored.
        reqM[3] = 1'b1; opM[3] = 2'b01; drive();
        runTxn(4'b1000, 1'b0, 1'b0, 1'b0, src);

        // All caches invalidating, requests held: strict rotation.
        reqM = '1;
        for (int i = 0; i < N; i++) opM[i] = 2'b11;
        drive();
        for (int k = 0; k < 5; k++) begin
            runTxn(4'b1111, 1'b0, 1'b1, 1'b0, src);
            chk("rr_order", src, order[k]);
        end
        reqM = '0;
        drive();

        // Reset during MEM: no done, pointer returns to 0.
        reqM[2] = 1'b1; opM[2] = 2'b01; drive();
        @(negedge clock); chk("abort.bcast", bus.state, S_BCAST);
        @(negedge clock); chk("abort.snoop", bus.state, S_SNOOP);
        @(negedge clock); chk("abort.mem", bus.state, S_MEM);
        reqM[2] = 1'b0; drive();
        #1 reset_n = 1'b0;
        #1 checkOut("abort.reset", S_IDLE, 0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checkOut("abort.idle", S_IDLE, 0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        reqM = 4'b1010; opM[1] = 2'b01; opM[3] = 2'b01; drive();
        rrModel = 0;
        runTxn('0, 1'b0, 1'b0, 1'b0, src);
        chk("rr_after_reset", src, 1);
        reqM = '0;
        drive();

        // Randomized traffic: waiting requests stay held, owners scribble on their op mid-flight.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!reqM[i] && ($urandom_range(0, 1) == 1)) begin
                    reqM[i] = 1'b1;
                    opM[i]  = 2'($urandom_range(0, 3));
                end else if (reqM[i] && opM[i] == 2'b00 && ($urandom_range(0, 1) == 1)) begin
                    reqM[i] = 1'b0;
                end
            end
            if (pickWinner(rrModel) < 0) begin
                r = int'($urandom_range(0, N - 1));
                reqM[r] = 1'b1;
                opM[r]  = 2'($urandom_range(1, 3));
            end
            drive();
            snp = ($urandom_range(0, 1) == 1) ? N'($urandom) : '0;
            runTxn(snp, 1'b1, 1'b0, 1'b1, src);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
